// File: rtl/memory_controller_pkg.sv
// Shared constants and types for the byte-serial RAM controller.
package memory_controller_pkg;
   localparam int          LSB_CAP_BIT        = 3;
   localparam logic [1:0]  LEN_B              = 2'b00;
   localparam logic [1:0]  LEN_H              = 2'b01;
   localparam logic [1:0]  LEN_W              = 2'b10;
   localparam logic [31:0] IO_ADDR_LO_DEFAULT = 32'h0003_0000;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
   typedef enum logic {OWN_FETCH, OWN_LSB} owner_e;

   // The reserved length code 2'b11 is treated as a word access.
   function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
      case (len)
         LEN_B:   return 3'd1;
         LEN_H:   return 3'd2;
         LEN_W:   return 3'd4;
         default: return 3'd4;
      endcase
   endfunction
endpackage

// File: rtl/memory_controller.sv
// Serialises one fetch or load/store at a time into byte transactions on a
// single-port RAM, reassembling read bytes little-endian.
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter logic [31:0] IO_ADDR_LO = IO_ADDR_LO_DEFAULT
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   clear,
   input  logic                   io_buffer_full,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [31:0]            mem_a,
   output logic                   mem_wr,
   input  logic                   if_req,
   input  logic [31:0]            if_addr,
   output logic                   if_ready,
   output logic [31:0]            if_data,
   input  logic                   lsb_req,
   input  logic [LSB_CAP_BIT-1:0] lsb_pos,
   input  logic                   lsb_ls,
   input  logic [1:0]             lsb_len,
   input  logic [31:0]            lsb_addr,
   input  logic [31:0]            lsb_val,
   output logic                   lsb_busy,
   output logic                   lsb_finished,
   output logic [31:0]            lsb_val_out,
   output logic [LSB_CAP_BIT-1:0] lsb_pos_out
);
   state_e                 state_q, state_d;
   owner_e                 owner_q, owner_d;
   logic                   store_q, store_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [2:0]             len_q, len_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            val_q, val_d;
   logic [31:0]            res_q, res_d;
   logic [LSB_CAP_BIT-1:0] pos_q, pos_d;
   logic [31:0]            if_hold_q, if_hold_d;
   logic [31:0]            val_hold_q, val_hold_d;
   logic [LSB_CAP_BIT-1:0] pos_hold_q, pos_hold_d;
   logic [31:0]            cur_a;
   logic                   io_stall;
   logic                   done_ok;

   assign cur_a    = addr_q + {29'd0, cnt_q};
   assign io_stall = io_buffer_full && (cur_a >= IO_ADDR_LO);
   assign lsb_busy = (state_q != ST_IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_LSB;
         store_q    <= 1'b0;
         cnt_q      <= 3'd0;
         len_q      <= 3'd0;
         if_hold_q  <= 32'd0;
         val_hold_q <= 32'd0;
         pos_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         store_q    <= store_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         if_hold_q  <= if_hold_d;
         val_hold_q <= val_hold_d;
         pos_hold_q <= pos_hold_d;
      end
   end

   always_ff @(posedge clk_in) begin
      addr_q <= addr_d;
      val_q  <= val_d;
      res_q  <= res_d;
      pos_q  <= pos_d;
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      store_d    = store_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      addr_d     = addr_q;
      val_d      = val_q;
      res_d      = res_q;
      pos_d      = pos_q;
      if_hold_d  = if_ready ? res_q : if_hold_q;
      val_hold_d = (lsb_finished && !store_q) ? res_q : val_hold_q;
      pos_hold_d = lsb_finished ? pos_q : pos_hold_q;
      if (rdy_in) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!clear && (lsb_req || if_req)) begin
                  cnt_d = 3'd0;
                  res_d = 32'd0;
                  if (lsb_req) begin
                     owner_d = OWN_LSB;
                     store_d = lsb_ls;
                     len_d   = len_to_bytes(lsb_len);
                     addr_d  = lsb_addr;
                     val_d   = lsb_val;
                     pos_d   = lsb_pos;
                     state_d = lsb_ls ? ST_WRITE : ST_READ;
                  end else begin
                     owner_d = OWN_FETCH;
                     store_d = 1'b0;
                     len_d   = 3'd4;
                     addr_d  = if_addr;
                     state_d = ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (clear) begin
                  state_d = ST_IDLE;
               end else begin
                  // Byte addressed at count k-1 arrives while the count is k.
                  case (cnt_q)
                     3'd0:    ;
                     3'd1:    res_d[7:0]   = mem_din;
                     3'd2:    res_d[15:8]  = mem_din;
                     3'd3:    res_d[23:16] = mem_din;
                     default: res_d[31:24] = mem_din;
                  endcase
                  if (cnt_q == len_q) state_d = ST_DONE;
                  else                cnt_d   = cnt_q + 3'd1;
               end
            end
            ST_WRITE: begin
               if (!io_stall) begin
                  if (cnt_q == len_q - 3'd1) state_d = ST_DONE;
                  else                       cnt_d   = cnt_q + 3'd1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mem_a        = 32'd0;
      mem_dout     = 8'd0;
      mem_wr       = 1'b0;
      done_ok      = rdy_in && (state_q == ST_DONE) && !(clear && !store_q);
      if_ready     = done_ok && (owner_q == OWN_FETCH);
      lsb_finished = done_ok && (owner_q == OWN_LSB);
      if_data      = if_ready ? res_q : if_hold_q;
      lsb_val_out  = (lsb_finished && !store_q) ? res_q : val_hold_q;
      lsb_pos_out  = lsb_finished ? pos_q : pos_hold_q;
      unique case (state_q)
         ST_READ: begin
            // While frozen, re-address the previous byte so it is still on
            // mem_din when the pending capture finally happens.
            if (!rdy_in && cnt_q != 3'd0) mem_a = cur_a - 32'd1;
            else if (cnt_q < len_q)       mem_a = cur_a;
         end
         ST_WRITE: begin
            mem_a  = cur_a;
            mem_wr = rdy_in && !io_stall;
            case (cnt_q)
               3'd0:    mem_dout = val_q[7:0];
               3'd1:    mem_dout = val_q[15:8];
               3'd2:    mem_dout = val_q[23:16];
               default: mem_dout = val_q[31:24];
            endcase
         end
         default: ;
      endcase
   end
endmodule
